// File: rtl/bcd_multi_timer_if.sv
// ---------------------------------------------------------------------------------------------
// bcd_multi_timer_if
//   Control/data bundle between the keypad/programming logic (master) and the BCD timer
//   (slave).
//
//   Parameters:
//     NUM_FIELDS  number of two-digit BCD fields carried on prog/count
//
//   Signals:
//     tick     master -> slave  one-cycle count strobe (1 Hz enable)
//     load     master -> slave  load prog into count
//     start    master -> slave  begin or resume counting
//     pause    master -> slave  suspend counting
//     prog     master -> slave  programmed time, BCD, nibble 0 = seconds units
//     count    slave -> master  current time, same packing as prog
//     running  slave -> master  high while counting
//     done     slave -> master  one-cycle pulse on terminal count
//     alarm    slave -> master  level, high once terminal count has been reached
// ---------------------------------------------------------------------------------------------
interface bcd_multi_timer_if #(
    parameter int unsigned NUM_FIELDS = 2
);
    logic                      tick;
    logic                      load;
    logic                      start;
    logic                      pause;
    logic [8*NUM_FIELDS-1:0]   prog;
    logic [8*NUM_FIELDS-1:0]   count;
    logic                      running;
    logic                      done;
    logic                      alarm;

    modport master (
        output tick, load, start, pause, prog,
        input  count, running, done, alarm
    );

    modport slave (
        input  tick, load, start, pause, prog,
        output count, running, done, alarm
    );
endinterface

// File: rtl/bcd_multi_timer.sv
// ---------------------------------------------------------------------------------------------
// bcd_multi_timer
//   Parametrised BCD interval timer built from NUM_FIELDS two-digit fields. Lower fields count
//   00-59, the top field counts 00-99 (e.g. MM:SS or HH:MM:SS). Counts down to all zeros or up
//   to all-maximum on each tick while running, saturates at that terminal count, pulses done
//   and raises alarm. Loaded values are sanitised digit by digit.
//
//   Optional build macro: BCD_TIMER_AUTO_RELOAD_EN
//     When defined, a shadow copy of the last accepted load is reloaded on terminal count and
//     the timer keeps running (unless the shadow itself is the terminal value).
//
//   Parameters:
//     NUM_FIELDS  number of two-digit fields (1..4), field 0 = seconds
//     DIRECTION   0 = count down to zero, 1 = count up to maximum
//
//   Ports:
//     clk_i     system clock
//     reset_ni  synchronous active-low reset
//     bus       bcd_multi_timer_if slave modport (tick/load/start/pause/prog in,
//               count/running/done/alarm out)
// ---------------------------------------------------------------------------------------------
module bcd_multi_timer #(
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned DIRECTION  = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    bcd_multi_timer_if.slave      bus
);

    localparam int unsigned W = 8 * NUM_FIELDS;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    // Largest legal value of digit i (even = units, odd = tens; only the top tens reach 9).
    function automatic logic [3:0] digit_max(input int unsigned i);
        if (i[0] == 1'b0) begin
            return 4'd9;
        end else if ((i / 2) == (NUM_FIELDS - 1)) begin
            return 4'd9;
        end else begin
            return 4'd5;
        end
    endfunction

    function automatic logic [W-1:0] terminal_count();
        logic [W-1:0] r;
        r = '0;
        if (DIRECTION != 0) begin
            for (int unsigned i = 0; i < 2 * NUM_FIELDS; i++) begin
                r[4*i +: 4] = digit_max(i);
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] Terminal = terminal_count();

    // Clamp every digit of a programmed value to its legal maximum.
    function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = v;
        for (int unsigned i = 0; i < 2 * NUM_FIELDS; i++) begin
            d = v[4*i +: 4];
            if (d > digit_max(i)) begin
                r[4*i +: 4] = digit_max(i);
            end
        end
        return r;
    endfunction

    // One-second step with a ripple borrow (down) or carry (up) through all digits.
    function automatic logic [W-1:0] step(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        logic [3:0]   d;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < 2 * NUM_FIELDS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (DIRECTION == 0) begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = digit_max(i);
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == digit_max(i)) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q,  done_d;
    logic [W-1:0]   prog_san;
    logic [W-1:0]   stepped;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [W-1:0]   shadow_q, shadow_d;
`endif

    assign prog_san = sanitise(bus.prog);
    assign stepped  = step(count_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        shadow_d = shadow_q;
        if (bus.load && (state_q != StRun)) begin
            shadow_d = prog_san;
        end
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    count_d = prog_san;
                end else if (bus.start) begin
                    if (count_q == Terminal) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // load and start have no effect here; pause swallows a same-cycle tick.
                if (bus.pause) begin
                    state_d = StPause;
                end else if (bus.tick) begin
                    count_d = stepped;
                    if (stepped == Terminal) begin
                        done_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        // A terminal shadow would reload straight into terminal forever.
                        if (shadow_q != Terminal) begin
                            count_d = shadow_q;
                        end else begin
                            state_d = StDone;
                        end
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            StPause: begin
                if (bus.load) begin
                    count_d = prog_san;
                    state_d = StIdle;
                end else if (bus.start) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (bus.load) begin
                    count_d = prog_san;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            shadow_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign bus.count   = count_q;
    assign bus.running = (state_q == StRun);
    assign bus.alarm   = (state_q == StDone);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_multi_timer.sv
// ---------------------------------------------------------------------------------------------
// tb_bcd_multi_timer
//   Self-checking bench for bcd_multi_timer. Two instances run side by side: a two-field
//   down-counter and a three-field up-counter. A reference model tracks each timer as an
//   integer number of seconds and converts to BCD only for comparison. Directed sequences are
//   followed by randomized stimulus. Honors BCD_TIMER_AUTO_RELOAD_EN the same way as the RTL.
// ---------------------------------------------------------------------------------------------
module tb_bcd_multi_timer;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_LD   = 4'b1000;
    localparam logic [3:0] C_ST   = 4'b0100;
    localparam logic [3:0] C_PS   = 4'b0010;
    localparam logic [3:0] C_TK   = 4'b0001;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_multi_timer_if #(.NUM_FIELDS(2)) if0 ();
    bcd_multi_timer_if #(.NUM_FIELDS(3)) if1 ();

    bcd_multi_timer #(.NUM_FIELDS(2), .DIRECTION(0)) dut0 (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (if0)
    );

    bcd_multi_timer #(.NUM_FIELDS(3), .DIRECTION(1)) dut1 (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (if1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_state  [2];
    int m_secs   [2];
    int m_shadow [2];
    bit m_done   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nf_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int max_secs(input int nf);
        int m;
        m = 100;
        for (int f = 1; f < nf; f++) m = m * 60;
        return m - 1;
    endfunction

    function automatic int to_secs(input logic [31:0] bcd, input int nf);
        int s;
        int mul;
        s   = 0;
        mul = 1;
        for (int f = 0; f < nf; f++) begin
            s   = s + (int'(bcd[8*f+4 +: 4]) * 10 + int'(bcd[8*f +: 4])) * mul;
            mul = mul * 60;
        end
        return s;
    endfunction

    function automatic logic [31:0] to_bcd(input int secs, input int nf);
        logic [31:0] r;
        int s;
        int v;
        r = '0;
        s = secs;
        for (int f = 0; f < nf; f++) begin
            v = (f == nf - 1) ? s : s % 60;
            s = s / 60;
            r[8*f +: 8] = {4'(v / 10), 4'(v % 10)};
        end
        return r;
    endfunction

    // Programmed value -> seconds, with out-of-range digits clamped first.
    function automatic int san_secs(input logic [31:0] p, input int nf);
        logic [31:0] c;
        int u;
        int t;
        int tmax;
        c = '0;
        for (int f = 0; f < nf; f++) begin
            u    = int'(p[8*f +: 4]);
            t    = int'(p[8*f+4 +: 4]);
            tmax = (f == nf - 1) ? 9 : 5;
            if (u > 9) u = 9;
            if (t > tmax) t = tmax;
            c[8*f +: 8] = {4'(t), 4'(u)};
        end
        return to_secs(c, nf);
    endfunction

    task automatic model_step(input int d, input logic rst, input logic [3:0] c,
                              input logic [31:0] p);
        int nf;
        int term;
        int san;
        nf   = nf_of(d);
        term = (d == 0) ? 0 : max_secs(nf);
        san  = san_secs(p, nf);
        if (!rst) begin
            m_state[d]  = S_IDLE;
            m_secs[d]   = 0;
            m_shadow[d] = 0;
            m_done[d]   = 1'b0;
            return;
        end
        m_done[d] = 1'b0;
        case (m_state[d])
            S_IDLE: begin
                if (c[3]) begin
                    m_secs[d]   = san;
                    m_shadow[d] = san;
                end else if (c[2]) begin
                    if (m_secs[d] == term) begin
                        m_state[d] = S_DONE;
                        m_done[d]  = 1'b1;
                    end else begin
                        m_state[d] = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (c[1]) begin
                    m_state[d] = S_PAUSE;
                end else if (c[0]) begin
                    m_secs[d] = (d == 0) ? m_secs[d] - 1 : m_secs[d] + 1;
                    if (m_secs[d] == term) begin
                        m_done[d] = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        if (m_shadow[d] != term) m_secs[d] = m_shadow[d];
                        else m_state[d] = S_DONE;
`else
                        m_state[d] = S_DONE;
`endif
                    end
                end
            end
            S_PAUSE: begin
                if (c[3]) begin
                    m_secs[d]   = san;
                    m_shadow[d] = san;
                    m_state[d]  = S_IDLE;
                end else if (c[2]) begin
                    m_state[d] = S_RUN;
                end
            end
            default: begin
                if (c[3]) begin
                    m_secs[d]   = san;
                    m_shadow[d] = san;
                    m_state[d]  = S_IDLE;
                end
            end
        endcase
    endtask

    task automatic cyc(input logic rst, input logic [3:0] c0, input logic [31:0] p0,
                       input logic [3:0] c1, input logic [31:0] p1);
        @(negedge clk);
        rst_n     = rst;
        if0.load  = c0[3];
        if0.start = c0[2];
        if0.pause = c0[1];
        if0.tick  = c0[0];
        if0.prog  = p0[15:0];
        if1.load  = c1[3];
        if1.start = c1[2];
        if1.pause = c1[1];
        if1.tick  = c1[0];
        if1.prog  = p1[23:0];
        @(posedge clk);
        model_step(0, rst, c0, p0);
        model_step(1, rst, c1, p1);
        #1;
        check("cnt0",   {16'h0, if0.count},   to_bcd(m_secs[0], 2));
        check("run0",   {31'h0, if0.running}, {31'h0, m_state[0] == S_RUN});
        check("alarm0", {31'h0, if0.alarm},   {31'h0, m_state[0] == S_DONE});
        check("done0",  {31'h0, if0.done},    {31'h0, m_done[0]});
        check("cnt1",   {8'h0, if1.count},    to_bcd(m_secs[1], 3));
        check("run1",   {31'h0, if1.running}, {31'h0, m_state[1] == S_RUN});
        check("alarm1", {31'h0, if1.alarm},   {31'h0, m_state[1] == S_DONE});
        check("done1",  {31'h0, if1.done},    {31'h0, m_done[1]});
    endtask

    // Dut0-only cycle.
    task automatic c0(input logic [3:0] c, input logic [31:0] p);
        cyc(1'b1, c, p, C_NONE, 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        if0.load  = 1'b0; if0.start = 1'b0; if0.pause = 1'b0; if0.tick = 1'b0; if0.prog = '0;
        if1.load  = 1'b0; if1.start = 1'b0; if1.pause = 1'b0; if1.tick = 1'b0; if1.prog = '0;

        cyc(1'b0, C_NONE, 32'h0, C_NONE, 32'h0);
        cyc(1'b0, C_TK, 32'h1234, C_LD, 32'h123456);
        check("rst_cnt0", {16'h0, if0.count}, 32'h0);
        check("rst_run0", {31'h0, if0.running}, 32'h0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
        c0(C_LD, 32'h0002);
        c0(C_ST, 32'h0);
        c0(C_TK, 32'h0); check("ar_t1", {16'h0, if0.count}, 32'h0001);
        c0(C_TK, 32'h0); check("ar_t2", {16'h0, if0.count}, 32'h0002);
        check("ar_d2", {31'h0, if0.done}, 32'h1);
        check("ar_r2", {31'h0, if0.running}, 32'h1);
        c0(C_TK, 32'h0); check("ar_t3", {16'h0, if0.count}, 32'h0001);
        c0(C_TK, 32'h0); check("ar_t4", {16'h0, if0.count}, 32'h0002);
        check("ar_d4", {31'h0, if0.done}, 32'h1);
        check("ar_r4", {31'h0, if0.running}, 32'h1);
        c0(C_PS, 32'h0);
`else
        // Countdown to zero, saturation and alarm.
        c0(C_LD, 32'h0003);
        c0(C_ST, 32'h0);
        c0(C_TK, 32'h0); check("t1_a", {16'h0, if0.count}, 32'h0002);
        c0(C_TK, 32'h0); check("t1_b", {16'h0, if0.count}, 32'h0001);
        c0(C_TK, 32'h0); check("t1_c", {16'h0, if0.count}, 32'h0000);
        check("t1_done", {31'h0, if0.done}, 32'h1);
        check("t1_alarm", {31'h0, if0.alarm}, 32'h1);
        c0(C_TK, 32'h0); check("t1_sat", {16'h0, if0.count}, 32'h0000);
        check("t1_done_once", {31'h0, if0.done}, 32'h0);
        // Cross-field borrows.
        c0(C_LD, 32'h0100);
        c0(C_ST, 32'h0);
        c0(C_TK, 32'h0); check("t2_a", {16'h0, if0.count}, 32'h0059);
        c0(C_PS, 32'h0);
        c0(C_LD, 32'h1000);
        c0(C_ST, 32'h0);
        c0(C_TK, 32'h0); check("t2_b", {16'h0, if0.count}, 32'h0959);
        // Sanitising and load ignored in RUN.
        c0(C_PS, 32'h0);
        c0(C_LD, 32'h007F); check("t3_san", {16'h0, if0.count}, 32'h0059);
        c0(C_ST, 32'h0);
        c0(C_LD, 32'h0012); check("t3_ign", {16'h0, if0.count}, 32'h0059);
        // Pause swallows the same-cycle tick.
        c0(C_PS, 32'h0);
        c0(C_LD, 32'h0010);
        c0(C_ST, 32'h0);
        c0(C_PS | C_TK, 32'h0); check("t4_hold", {16'h0, if0.count}, 32'h0010);
        check("t4_run", {31'h0, if0.running}, 32'h0);
        c0(C_TK, 32'h0);
        c0(C_TK, 32'h0); check("t4_ign", {16'h0, if0.count}, 32'h0010);
        c0(C_ST, 32'h0); check("t4_res", {31'h0, if0.running}, 32'h1);
        c0(C_TK, 32'h0); check("t4_step", {16'h0, if0.count}, 32'h0009);
        // Up-counter reaching the all-maximum terminal.
        cyc(1'b1, C_PS, 32'h0, C_LD, 32'h995957);
        cyc(1'b1, C_NONE, 32'h0, C_ST, 32'h0);
        cyc(1'b1, C_NONE, 32'h0, C_TK, 32'h0);
        check("t5_a", {8'h0, if1.count}, 32'h995958);
        cyc(1'b1, C_NONE, 32'h0, C_TK, 32'h0);
        check("t5_b", {8'h0, if1.count}, 32'h995959);
        check("t5_done", {31'h0, if1.done}, 32'h1);
        check("t5_alarm", {31'h0, if1.alarm}, 32'h1);
`endif
        // Reset in the middle of a run.
        cyc(1'b1, C_NONE, 32'h0, C_LD, 32'h000100);
        cyc(1'b1, C_NONE, 32'h0, C_ST, 32'h0);
        cyc(1'b1, C_NONE, 32'h0, C_TK, 32'h0);
        check("t5_up", {8'h0, if1.count}, 32'h000101);
        cyc(1'b0, C_NONE, 32'h0, C_TK, 32'h0);
        check("t5_rst_cnt", {8'h0, if1.count}, 32'h0);
        check("t5_rst_run", {31'h0, if1.running}, 32'h0);

        // Randomized stimulus, biased so both timers regularly reach terminal count.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  ca;
            logic [3:0]  cb;
            logic [31:0] pa;
            logic [31:0] pb;
            logic        r;
            r = ($urandom % 97) != 0;
            for (int k = 0; k < 2; k++) begin
                logic [3:0] c;
                c[3] = ($urandom % 8) == 0;
                c[2] = ($urandom % 6) == 0;
                c[1] = !c[2] && (($urandom % 10) == 0);
                c[0] = ($urandom % 2) == 0;
                if (k == 0) ca = c;
                else cb = c;
            end
            pa = (($urandom % 4) == 0) ? ($urandom % 6) : $urandom;
            pb = (($urandom % 4) == 0) ? (32'h995950 | ($urandom % 10)) : $urandom;
            cyc(r, ca, pa, cb, pb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
